// File: rtl/btb_pkg.sv
// Shared types and default sizing for the associative agree BTB.
package btb_pkg;

    localparam int unsigned DEF_INDEX_WIDTH = 4;
    localparam int unsigned DEF_NUM_WAYS    = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } flush_state_e;

endpackage

// File: rtl/btb_way.sv
// One BTB way: per-set valid/tag/target/bias with async read, sync write, per-set clear.
module btb_way #(
    parameter int unsigned INDEX_WIDTH = 4,
    parameter int unsigned TAG_W       = 26
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    // lookup read port
    input  logic [INDEX_WIDTH-1:0] rd_idx,
    output logic                   rd_valid,
    output logic [TAG_W-1:0]       rd_tag,
    output logic [31:0]            rd_target,
    output logic                   rd_bias,
    // update read port, also the write address
    input  logic [INDEX_WIDTH-1:0] up_idx,
    output logic                   up_valid,
    output logic [TAG_W-1:0]       up_tag,
    // write controls
    input  logic                   alloc_en,
    input  logic                   tgt_en,
    input  logic [TAG_W-1:0]       wr_tag,
    input  logic [31:0]            wr_target,
    input  logic                   wr_bias,
    // flush clear
    input  logic                   clr_en,
    input  logic [INDEX_WIDTH-1:0] clr_idx
);

    localparam int unsigned SETS = 1 << INDEX_WIDTH;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q    [SETS];
    logic [31:0]      target_q [SETS];
    logic             bias_q   [SETS];

    // Valid bits: reset and flush clear them, allocation sets them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (clr_en) begin
            valid_q[clr_idx] <= 1'b0;
        end else if (alloc_en) begin
            valid_q[up_idx] <= 1'b1;
        end
    end

    // Payload storage is left unreset; valid masks stale contents.
    always_ff @(posedge clk_i) begin
        if (alloc_en) begin
            tag_q[up_idx]  <= wr_tag;
            bias_q[up_idx] <= wr_bias;
        end
        if (alloc_en || tgt_en) begin
            target_q[up_idx] <= wr_target;
        end
    end

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_q[rd_idx];
    assign rd_target = target_q[rd_idx];
    assign rd_bias   = bias_q[rd_idx];
    assign up_valid  = valid_q[up_idx];
    assign up_tag    = tag_q[up_idx];

endmodule

// File: rtl/assoc_agree_btb.sv
// Set-associative BTB with agree bias, round-robin replacement and a sequential flush.
module assoc_agree_btb
    import btb_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int unsigned NUM_WAYS    = DEF_NUM_WAYS
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [31:0]                 rd_pc_i,
    output logic                        hit_o,
    output logic [31:0]                 target_o,
    output logic                        bias_o,
    output logic [$clog2(NUM_WAYS)-1:0] hit_way_o,
    input  logic                        wr_en_i,
    input  logic [31:0]                 wr_pc_i,
    input  logic [31:0]                 wr_target_i,
    input  logic                        wr_taken_i,
    input  logic                        flush_i,
    output logic                        busy_o
);

    localparam int unsigned WAY_W = $clog2(NUM_WAYS);
    localparam int unsigned TAG_W = 30 - INDEX_WIDTH;
    localparam int unsigned SETS  = 1 << INDEX_WIDTH;

    // PC field split; the byte offset bits carry no information.
    logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0]       rd_tag, wr_tag;
    logic                   unused_pc_lsbs;

    assign rd_idx         = rd_pc_i[INDEX_WIDTH+1:2];
    assign rd_tag         = rd_pc_i[31:INDEX_WIDTH+2];
    assign wr_idx         = wr_pc_i[INDEX_WIDTH+1:2];
    assign wr_tag         = wr_pc_i[31:INDEX_WIDTH+2];
    assign unused_pc_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

    flush_state_e           state_q, state_d;
    logic [INDEX_WIDTH-1:0] cnt_q, cnt_d;
    logic                   clr_en;
    logic                   busy;

    assign busy   = (state_q == ST_FLUSH);
    assign busy_o = busy;

    logic [NUM_WAYS-1:0] rd_valid_w, rd_bias_w, up_valid_w;
    logic [TAG_W-1:0]    rd_tag_w    [NUM_WAYS];
    logic [31:0]         rd_target_w [NUM_WAYS];
    logic [TAG_W-1:0]    up_tag_w    [NUM_WAYS];
    logic [NUM_WAYS-1:0] alloc_en_w, tgt_en_w;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        btb_way #(
            .INDEX_WIDTH (INDEX_WIDTH),
            .TAG_W       (TAG_W)
        ) u_way (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .rd_idx    (rd_idx),
            .rd_valid  (rd_valid_w[w]),
            .rd_tag    (rd_tag_w[w]),
            .rd_target (rd_target_w[w]),
            .rd_bias   (rd_bias_w[w]),
            .up_idx    (wr_idx),
            .up_valid  (up_valid_w[w]),
            .up_tag    (up_tag_w[w]),
            .alloc_en  (alloc_en_w[w]),
            .tgt_en    (tgt_en_w[w]),
            .wr_tag    (wr_tag),
            .wr_target (wr_target_i),
            .wr_bias   (wr_taken_i),
            .clr_en    (clr_en),
            .clr_idx   (cnt_q)
        );
    end

    // Combinational lookup; lowest matching way wins, everything masked while flushing.
    always_comb begin
        hit_o     = 1'b0;
        target_o  = '0;
        bias_o    = 1'b0;
        hit_way_o = '0;
        if (!busy) begin
            for (int w = NUM_WAYS - 1; w >= 0; w--) begin
                if (rd_valid_w[w] && (rd_tag_w[w] == rd_tag)) begin
                    hit_o     = 1'b1;
                    target_o  = rd_target_w[w];
                    bias_o    = rd_bias_w[w];
                    hit_way_o = WAY_W'(w);
                end
            end
        end
    end

    logic [SETS-1:0][WAY_W-1:0] ptr_q;
    logic                       wr_accept;
    logic                       up_hit, has_free;
    logic [WAY_W-1:0]           up_way, free_way, victim;

    // Writes are dropped while flushing and when a flush request arrives in the same cycle.
    assign wr_accept = wr_en_i && !busy && !flush_i;

    // Update-side tag match and victim choice: lowest invalid way, else the round-robin pointer.
    always_comb begin
        up_hit   = 1'b0;
        up_way   = '0;
        has_free = 1'b0;
        free_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (up_valid_w[w] && (up_tag_w[w] == wr_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!up_valid_w[w]) begin
                has_free = 1'b1;
                free_way = WAY_W'(w);
            end
        end
        victim = has_free ? free_way : ptr_q[wr_idx];
    end

    // Per-way write strobes: full allocation on miss, target-only rewrite on hit.
    always_comb begin
        alloc_en_w = '0;
        tgt_en_w   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            alloc_en_w[w] = wr_accept && !up_hit && (victim == WAY_W'(w));
            tgt_en_w[w]   = wr_accept &&  up_hit && (up_way == WAY_W'(w));
        end
    end

    // Victim pointers advance only when a full set is evicted; flush clears them per set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (clr_en) begin
            ptr_q[cnt_q] <= '0;
        end else if (wr_accept && !up_hit && !has_free) begin
            ptr_q[wr_idx] <= ptr_q[wr_idx] + WAY_W'(1);
        end
    end

    // Flush FSM state and set counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Flush FSM next state: one set cleared per cycle, a new request restarts at set 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                clr_en = 1'b1;
                if (flush_i) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + INDEX_WIDTH'(1);
                    if (&cnt_q) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_assoc_agree_btb.sv
// Self-checking bench for assoc_agree_btb (INDEX_WIDTH=4, NUM_WAYS=2).
module tb_assoc_agree_btb;

    logic        clk;
    logic        rst_n;
    logic [31:0] rd_pc;
    logic        hit;
    logic [31:0] target;
    logic        bias;
    logic [0:0]  hit_way;
    logic        wr_en;
    logic [31:0] wr_pc;
    logic [31:0] wr_target;
    logic        wr_taken;
    logic        flush;
    logic        busy;

    assoc_agree_btb #(
        .INDEX_WIDTH (4),
        .NUM_WAYS    (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .rd_pc_i     (rd_pc),
        .hit_o       (hit),
        .target_o    (target),
        .bias_o      (bias),
        .hit_way_o   (hit_way),
        .wr_en_i     (wr_en),
        .wr_pc_i     (wr_pc),
        .wr_target_i (wr_target),
        .wr_taken_i  (wr_taken),
        .flush_i     (flush),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic [31:0] tgt;
        logic        bias;
        logic [0:0]  way;
    } exp_t;

    typedef struct {
        bit          is_wr;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
        logic        e_hit;
        logic [31:0] e_tgt;
        logic        e_bias;
        logic [0:0]  e_way;
    } vec_t;

    exp_t  sb_q   [$];
    string name_q [$];
    int    tests  = 0;
    int    failed = 0;
    vec_t  vecs   [20];

    // Pop the oldest expectation and compare it with the settled lookup outputs.
    task automatic check_out();
        exp_t  e;
        exp_t  a;
        string nm;
        e  = sb_q.pop_front();
        nm = name_q.pop_front();
        a  = '{hit: hit, tgt: target, bias: bias, way: hit_way};
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got hit=%0b tgt=%h bias=%0b way=%0d, want hit=%0b tgt=%h bias=%0b way=%0d",
                     nm, a.hit, a.tgt, a.bias, a.way, e.hit, e.tgt, e.bias, e.way);
        end
    endtask

    task automatic push_and_check(input string nm, input logic eh, input logic [31:0] et,
                                  input logic eb, input logic [0:0] ew);
        sb_q.push_back('{hit: eh, tgt: et, bias: eb, way: ew});
        name_q.push_back(nm);
        #1;
        check_out();
    endtask

    task automatic expect_lookup(input string nm, input logic [31:0] pc, input logic eh,
                                 input logic [31:0] et, input logic eb, input logic [0:0] ew);
        @(negedge clk);
        rd_pc = pc;
        push_and_check(nm, eh, et, eb, ew);
    endtask

    task automatic expect_miss(input string nm, input logic [31:0] pc);
        expect_lookup(nm, pc, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] pc, input logic [31:0] tgt, input logic taken);
        @(negedge clk);
        wr_en     = 1'b1;
        wr_pc     = pc;
        wr_target = tgt;
        wr_taken  = taken;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;

        vecs[0]  = '{1'b0, 32'h0000_0040, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0040, 32'h1000, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0,    1'b0, 1'b1, 32'h1000, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0440, 32'h3000, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0440, 32'h0,    1'b0, 1'b1, 32'h3000, 1'b1, 1'b1};
        vecs[5]  = '{1'b1, 32'h0000_0840, 32'h4000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0040, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0840, 32'h0,    1'b0, 1'b1, 32'h4000, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h0000_0440, 32'h0,    1'b0, 1'b1, 32'h3000, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 32'h0000_0440, 32'h2000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0440, 32'h0,    1'b0, 1'b1, 32'h2000, 1'b1, 1'b1};
        vecs[11] = '{1'b1, 32'h0000_0C40, 32'h5000, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[12] = '{1'b0, 32'h0000_0440, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0C40, 32'h0,    1'b0, 1'b1, 32'h5000, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 32'h0000_0840, 32'h0,    1'b0, 1'b1, 32'h4000, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 32'h0000_0044, 32'h6000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[16] = '{1'b0, 32'h0000_0044, 32'h0,    1'b0, 1'b1, 32'h6000, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 32'h0000_0047, 32'h0,    1'b0, 1'b1, 32'h6000, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 32'h0000_0048, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};
        vecs[19] = '{1'b0, 32'h8000_0840, 32'h0,    1'b0, 1'b0, 32'h0,    1'b0, 1'b0};

        rst_n     = 1'b0;
        rd_pc     = 32'h0;
        wr_en     = 1'b0;
        wr_pc     = 32'h0;
        wr_target = 32'h0;
        wr_taken  = 1'b0;
        flush     = 1'b0;

        // Reset state
        expect_miss("reset_lookup", 32'h0000_0040);
        check_int("reset_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: allocation, round-robin eviction, update-hit, index/tag/offset decoding
        for (int i = 0; i < 20; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].pc, vecs[i].tgt, vecs[i].taken);
            end else begin
                expect_lookup($sformatf("vec%0d", i), vecs[i].pc, vecs[i].e_hit,
                              vecs[i].e_tgt, vecs[i].e_bias, vecs[i].e_way);
            end
        end

        // Same-cycle lookup and update of one set: old contents now, new next cycle
        @(negedge clk);
        wr_en     = 1'b1;
        wr_pc     = 32'h0000_0050;
        wr_target = 32'h7000;
        wr_taken  = 1'b1;
        rd_pc     = 32'h0000_0050;
        push_and_check("bypass_pre", 1'b0, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        expect_lookup("bypass_post", 32'h0000_0050, 1'b1, 32'h7000, 1'b1, 1'b0);

        // Flush and write together in IDLE: flush wins, write dropped
        @(negedge clk);
        flush     = 1'b1;
        wr_en     = 1'b1;
        wr_pc     = 32'h0000_00B0;
        wr_target = 32'h8000;
        wr_taken  = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (c == 0) begin
                rd_pc = 32'h0000_0840;
                push_and_check("flush_mask_set0", 1'b0, 32'h0, 1'b0, 1'b0);
            end
            if (c == 2) begin
                rd_pc = 32'h0000_0044;
                push_and_check("flush_mask_set1", 1'b0, 32'h0, 1'b0, 1'b0);
            end
            if (c == 3) begin
                wr_en     = 1'b1;
                wr_pc     = 32'h0000_00A0;
                wr_target = 32'h9000;
                wr_taken  = 1'b1;
            end
            if (c == 4) wr_en = 1'b0;
        end
        check_int("flush_len", busy_cnt, 16);
        expect_miss("post_flush_840", 32'h0000_0840);
        expect_miss("post_flush_c40", 32'h0000_0C40);
        expect_miss("post_flush_044", 32'h0000_0044);
        expect_miss("post_flush_050", 32'h0000_0050);
        expect_miss("post_flush_wr_during", 32'h0000_00A0);
        expect_miss("post_flush_wr_dropped", 32'h0000_00B0);

        // After a flush the victim pointer restarts and ways fill from 0
        do_write(32'h0000_0040, 32'hA000, 1'b0);
        expect_lookup("refill_way0", 32'h0000_0040, 1'b1, 32'hA000, 1'b0, 1'b0);

        // flush_i during FLUSH restarts the set counter
        pulse_flush();
        busy_cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (c == 4) flush = 1'b1;
            if (c == 5) flush = 1'b0;
        end
        check_int("flush_restart_len", busy_cnt, 21);
        expect_miss("restart_after", 32'h0000_0040);

        // Reset in the middle of a flush aborts it and clears not-yet-flushed sets
        do_write(32'h0000_0068, 32'hB000, 1'b1);
        expect_lookup("pre_abort_hit", 32'h0000_0068, 1'b1, 32'hB000, 1'b1, 1'b0);
        pulse_flush();
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (busy_cnt == 5) break;
        end
        check_int("abort_reached_cycle5", busy_cnt, 5);
        rst_n = 1'b0;
        #1;
        check_int("abort_busy_now", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check_int("abort_no_more_flush", busy_cnt, 0);
        expect_miss("abort_entry_gone", 32'h0000_0068);
        do_write(32'h0000_0068, 32'hC000, 1'b0);
        expect_lookup("abort_idle_writes", 32'h0000_0068, 1'b1, 32'hC000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/assoc_agree_btb.md
ASSOC_AGREE_BTB -- requirements
Module: assoc_agree_btb

Interface
REQ-001 The block SHALL have parameter INDEX_WIDTH, default 4, giving log2 of the number of sets.
REQ-002 The block SHALL have parameter NUM_WAYS, default 2, giving the associativity; legal values are 2 and 4.
REQ-003 The block SHALL have port clk_i, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port rd_pc_i, input, 32 bits: lookup PC.
REQ-006 The block SHALL have port hit_o, output, 1 bit: a valid way of the lookup set matches the lookup tag.
REQ-007 The block SHALL have port target_o, output, 32 bits: stored target of the hit way; 0 on miss.
REQ-008 The block SHALL have port bias_o, output, 1 bit: stored agree bias of the hit way; 0 on miss.
REQ-009 The block SHALL have port hit_way_o, output, log2(NUM_WAYS) bits: index of the hit way; 0 on miss.
REQ-010 The block SHALL have port wr_en_i, input, 1 bit: update request from the resolving stage.
REQ-011 The block SHALL have port wr_pc_i, input, 32 bits: PC of the resolved branch.
REQ-012 The block SHALL have port wr_target_i, input, 32 bits: resolved target.
REQ-013 The block SHALL have port wr_taken_i, input, 1 bit: resolved direction, used as the bias on allocation.
REQ-014 The block SHALL have port flush_i, input, 1 bit: request to invalidate all entries.
REQ-015 The block SHALL have port busy_o, output, 1 bit: a flush is in progress.

Function
REQ-016 PC fields SHALL be: index = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2], which is 30-INDEX_WIDTH bits; pc[1:0] is ignored.
REQ-017 Lookup SHALL be combinational, with zero latency from rd_pc_i to hit_o, target_o, bias_o and hit_way_o.
REQ-018 Storage SHALL hold, per set and way: valid, tag, target and bias; plus one round-robin victim pointer per set, log2(NUM_WAYS) bits wide.
REQ-019 On an update-hit (wr_en_i=1, not busy, tag matches a valid way of the wr set), the block SHALL overwrite that way's target at the clock edge; bias SHALL be kept, and the victim pointer SHALL be unchanged.
REQ-020 On an update-miss, the block SHALL allocate the lowest-numbered invalid way of the set; if none is invalid, it SHALL allocate the way at the victim pointer and increment the pointer modulo NUM_WAYS.
REQ-021 On allocation, the block SHALL write tag, target and bias=wr_taken_i and set valid=1.
REQ-022 When the lookup and the update hit the same set in the same cycle, lookup SHALL return the pre-edge contents; the update SHALL be visible from the next cycle.
REQ-023 A flush SHALL be controlled by a two-state FSM, IDLE and FLUSH, with a set counter of INDEX_WIDTH bits.
REQ-024 IDLE -> FLUSH SHALL occur on flush_i=1, with the counter set to 0.
REQ-025 In FLUSH, each cycle SHALL clear valid for all ways of set[counter], clear that set's victim pointer, and increment the counter.
REQ-026 FLUSH -> IDLE SHALL occur after set 2^INDEX_WIDTH-1 is cleared; a flush therefore takes exactly 2^INDEX_WIDTH cycles.
REQ-027 busy_o SHALL be 1 exactly while the FSM is in FLUSH.
REQ-028 flush_i=1 while in FLUSH SHALL restart the counter at 0.
REQ-029 While busy_o=1, hit_o SHALL be forced to 0 (with target_o, bias_o and hit_way_o 0), and wr_en_i SHALL be ignored.
REQ-030 When flush_i and wr_en_i are both 1 in IDLE, the flush SHALL win and the write SHALL be dropped.

Reset
REQ-031 rst_ni=0 SHALL asynchronously clear every valid bit and victim pointer, put the FSM in IDLE, zero the counter, and drive busy_o=0 and hit_o=0.
REQ-032 Tag, target and bias arrays SHALL be non-reset storage; their contents are masked by valid.
REQ-033 Reset asserted mid-flush SHALL abort the flush and leave the FSM in IDLE after release; no further flush cycles SHALL occur.

Structure
REQ-034 A shared package btb_pkg SHALL hold the flush FSM state enum and the default INDEX_WIDTH and NUM_WAYS constants.
REQ-035 One sub-module, btb_way, SHALL hold one way's valid, tag, target and bias storage with async read, sync write and per-set valid clear; it SHALL be instantiated NUM_WAYS times.
REQ-036 Hit detection, victim selection, the victim pointers and the flush FSM SHALL live in the top module.

Verification (INDEX_WIDTH=4, NUM_WAYS=2)
REQ-037 Reset, then lookup 0x0000_0040 -> hit_o=0, target_o=0, busy_o=0.
REQ-038 Write pc 0x0000_0040, target 0x0000_1000, taken=1; next cycle lookup 0x0000_0040 -> hit_o=1, target_o=0x1000, bias_o=1, hit_way_o=0.
REQ-039 Allocate pcs 0x040, 0x440 and 0x840 (all index 0) -> 0x040 in way 0, 0x440 in way 1, 0x840 replaces way 0; lookup 0x040 misses, 0x440 hits way 1.
REQ-040 Re-write 0x440 with target 0x2000, taken=0 -> target_o=0x2000, bias_o stays 1, victim pointer unchanged.
REQ-041 flush_i pulse -> busy_o=1 for exactly 16 cycles; all lookups miss during and after; a wr_en_i issued during the flush leaves no entry.
REQ-042 Assert rst_ni=0 at flush cycle 5 -> busy_o=0 immediately; after release, no entries are valid and the FSM is in IDLE.
